// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter that shares one single-port RAM among NUM_REQ requesters.
// Define ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module ram_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      ram_we,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_din,
    input  logic [DATA_W-1:0]         ram_dout
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CAND_W = IDX_W + 1;

    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_rvalid;
    logic               r_ram_we;
    logic [ADDR_W-1:0]  r_ram_addr;
    logic [DATA_W-1:0]  r_ram_din;
    logic [IDX_W-1:0]   r_pend_idx;
    logic               r_pend_rd;

    logic [ADDR_W-1:0]  w_addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  w_wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0] w_elig;
    logic               w_found;
    logic [IDX_W-1:0]   w_win;
    logic [NUM_REQ-1:0] w_rv_next;

    genvar gi;
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
        assign w_wdata_arr[gi] = wdata[gi*DATA_W +: DATA_W];
    end

    // A requester holding a grant this cycle must not be granted again at this edge.
    assign w_elig = req & ~r_gnt;

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!w_found && w_elig[IDX_W'(k)]) begin
                w_found = 1'b1;
                w_win   = IDX_W'(k);
            end
        end
    end
`else
    logic [IDX_W-1:0]  r_last;
    logic [CAND_W-1:0] w_cand;

    // Search starts one past the previous winner and wraps modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_cand = {1'b0, r_last} + CAND_W'(k);
            if (w_cand >= CAND_W'(NUM_REQ)) begin
                w_cand = w_cand - CAND_W'(NUM_REQ);
            end
            if (!w_found && w_elig[w_cand[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last <= IDX_W'(NUM_REQ - 1);
        end else if (w_found) begin
            r_last <= w_win;
        end
    end
`endif

    always_comb begin
        w_rv_next = '0;
        if (r_pend_rd) begin
            w_rv_next[r_pend_idx] = 1'b1;
        end
    end

    // Grant, RAM control and read-tracking pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gnt      <= '0;
            r_rvalid   <= '0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            r_pend_idx <= '0;
            r_pend_rd  <= 1'b0;
        end else begin
            r_gnt     <= '0;
            r_ram_we  <= 1'b0;
            r_pend_rd <= 1'b0;
            r_rvalid  <= w_rv_next;
            if (w_found) begin
                r_gnt[w_win] <= 1'b1;
                r_ram_we     <= we[w_win];
                r_ram_addr   <= w_addr_arr[w_win];
                r_ram_din    <= w_wdata_arr[w_win];
                r_pend_idx   <= w_win;
                r_pend_rd    <= ~we[w_win];
            end
        end
    end

    assign gnt      = r_gnt;
    assign rvalid   = r_rvalid;
    assign ram_we   = r_ram_we;
    assign ram_addr = r_ram_addr;
    assign ram_din  = r_ram_din;
    assign rdata    = ram_dout;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed self-checking bench for ram_rr_arbiter with a behavioural write-first single-port RAM.
module tb_ram_rr_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned DATA_W  = 8;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic                      ram_we;
    logic [ADDR_W-1:0]         ram_addr;
    logic [DATA_W-1:0]         ram_din;
    logic [DATA_W-1:0]         ram_dout;

    logic [DATA_W-1:0] mem [16];
    logic              pl_en;
    logic [ADDR_W-1:0] pl_addr;
    logic [DATA_W-1:0] pl_data;

    int checks = 0;
    int errors = 0;

    ram_rr_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Write-first RAM with registered read; pl_* preloads contents while the arbiter is idle.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= ram_we ? ram_din : mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic w, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        req[i]                 = 1'b1;
        we[i]                  = w;
        addr[i*ADDR_W +: ADDR_W] = a;
        wdata[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (2) tick();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt: got %b expected 0000", gnt); end
        checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL rst_rvalid: got %b expected 0000", rvalid); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we: got %b expected 0", ram_we); end
        checks++; if (ram_addr !== 4'h0) begin errors++; $display("FAIL rst_ram_addr: got %h expected 0", ram_addr); end
        checks++; if (ram_din !== 8'h00) begin errors++; $display("FAIL rst_ram_din: got %h expected 00", ram_din); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        set_req(0, 1'b1, 4'h2, 8'hAA);
        tick();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wr_gnt: got %b expected 0001", gnt); end
        checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL wr_ram_we: got %b expected 1", ram_we); end
        checks++; if (ram_addr !== 4'h2) begin errors++; $display("FAIL wr_ram_addr: got %h expected 2", ram_addr); end
        checks++; if (ram_din !== 8'hAA) begin errors++; $display("FAIL wr_ram_din: got %h expected aa", ram_din); end
        set_req(0, 1'b0, 4'h2, 8'h00);
        tick();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL wr_excl_gnt: got %b expected 0000", gnt); end
        checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL wr_no_rvalid: got %b expected 0000", rvalid); end
        tick();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rd_gnt: got %b expected 0001", gnt); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rd_ram_we: got %b expected 0", ram_we); end
        req = '0;
        tick();
        checks++; if (rvalid !== 4'b0001) begin errors++; $display("FAIL rd_rvalid: got %b expected 0001", rvalid); end
        checks++; if (rdata !== 8'hAA) begin errors++; $display("FAIL rd_rdata: got %h expected aa", rdata); end
        tick();
        checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL rd_rvalid_pulse: got %b expected 0000", rvalid); end
    endtask

`ifndef ARB_FIXED_PRIO_EN
    task automatic test_all_read();
        logic [3:0] exp_g;
        logic [3:0] exp_v;
        logic [7:0] exp_d;
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) preload(4'(i), 8'h10 + 8'(i));
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 4'(i), 8'h00);
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_g = 4'b0001 << (k % 4);
            checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, gnt, exp_g); end
            if (k > 0) begin
                exp_v = 4'b0001 << ((k - 1) % 4);
                exp_d = 8'h10 + 8'((k - 1) % 4);
                checks++; if (rvalid !== exp_v) begin errors++; $display("FAIL rr_rvalid[%0d]: got %b expected %b", k, rvalid, exp_v); end
                checks++; if (rdata !== exp_d) begin errors++; $display("FAIL rr_rdata[%0d]: got %h expected %h", k, rdata, exp_d); end
            end
        end
        req = '0;
        tick();
        checks++; if (rvalid !== 4'b1000) begin errors++; $display("FAIL rr_last_rvalid: got %b expected 1000", rvalid); end
        checks++; if (rdata !== 8'h13) begin errors++; $display("FAIL rr_last_rdata: got %h expected 13", rdata); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rr_drain_gnt: got %b expected 0000", gnt); end
    endtask
`else
    task automatic test_fixed_prio();
        logic [3:0] exp_g;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        set_req(0, 1'b0, 4'h0, 8'h00);
        set_req(1, 1'b0, 4'h1, 8'h00);
        set_req(3, 1'b0, 4'h3, 8'h00);
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_g = (k % 2 == 0) ? 4'b0001 : 4'b0010;
            checks++; if (gnt !== exp_g) begin errors++; $display("FAIL fp_gnt[%0d]: got %b expected %b", k, gnt, exp_g); end
        end
        req = '0;
        repeat (2) tick();
    endtask
`endif

    task automatic test_raw();
        set_req(1, 1'b1, 4'h7, 8'h55);
        set_req(2, 1'b0, 4'h7, 8'h00);
        tick();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL raw_wgnt: got %b expected 0010", gnt); end
        checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL raw_ram_we: got %b expected 1", ram_we); end
        checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL raw_rvalid_c1: got %b expected 0000", rvalid); end
        req[1] = 1'b0;
        tick();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL raw_rgnt: got %b expected 0100", gnt); end
        checks++; if (ram_addr !== 4'h7) begin errors++; $display("FAIL raw_ram_addr: got %h expected 7", ram_addr); end
        checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL raw_rvalid_c2: got %b expected 0000", rvalid); end
        req[2] = 1'b0;
        tick();
        checks++; if (rvalid !== 4'b0100) begin errors++; $display("FAIL raw_rvalid: got %b expected 0100", rvalid); end
        checks++; if (rdata !== 8'h55) begin errors++; $display("FAIL raw_rdata: got %h expected 55", rdata); end
        tick();
        checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL raw_rvalid_c4: got %b expected 0000", rvalid); end
    endtask

    task automatic test_idle();
        logic [3:0] exp1;
        logic [3:0] exp2;
`ifdef ARB_FIXED_PRIO_EN
        exp1 = 4'b0001; exp2 = 4'b1000;
`else
        exp1 = 4'b1000; exp2 = 4'b0001;
`endif
        req = '0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (gnt !== 4'b0000 || rvalid !== 4'b0000 || ram_we !== 1'b0) begin
                errors++;
                $display("FAIL idle[%0d]: got gnt=%b rvalid=%b ram_we=%b expected 0000/0000/0", k, gnt, rvalid, ram_we);
            end
        end
        checks++; if (ram_addr !== 4'h7) begin errors++; $display("FAIL idle_hold_addr: got %h expected 7", ram_addr); end
        set_req(0, 1'b0, 4'h0, 8'h00);
        set_req(3, 1'b0, 4'h3, 8'h00);
        tick();
        checks++; if (gnt !== exp1) begin errors++; $display("FAIL idle_next_gnt: got %b expected %b", gnt, exp1); end
        req = req & ~exp1;
        tick();
        checks++; if (gnt !== exp2) begin errors++; $display("FAIL idle_second_gnt: got %b expected %b", gnt, exp2); end
        req = '0;
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_write();
        preload(4'h5, 8'h77);
        set_req(2, 1'b1, 4'h5, 8'h33);
        tick();
        checks++; if (gnt !== 4'b0100 || ram_we !== 1'b1) begin errors++; $display("FAIL mw_gnt: got gnt=%b ram_we=%b expected 0100/1", gnt, ram_we); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL mw_rst_gnt: got %b expected 0000", gnt); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL mw_rst_ram_we: got %b expected 0", ram_we); end
        checks++; if (ram_addr !== 4'h0 || ram_din !== 8'h00) begin errors++; $display("FAIL mw_rst_ram_bus: got addr=%h din=%h expected 0/00", ram_addr, ram_din); end
        checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL mw_rst_rvalid: got %b expected 0000", rvalid); end
        req = '0;
        tick();
        checks++; if (mem[5] !== 8'h77) begin errors++; $display("FAIL mw_mem5: got %h expected 77", mem[5]); end
        reset_n = 1'b1;
        set_req(2, 1'b0, 4'h5, 8'h00);
        set_req(3, 1'b0, 4'h5, 8'h00);
        tick();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL mw_ptr_gnt: got %b expected 0100", gnt); end
        req = '0;
        repeat (2) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
`ifndef ARB_FIXED_PRIO_EN
        test_all_read();
`else
        test_fixed_prio();
`endif
        test_raw();
        test_idle();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
